// File: rtl/ahb_arbiter_m3_pkg.sv
// ahb_defs: shared AHB encodings for the three-master arbiter.
//   htrans_e / hburst_e / hresp_e : bus field encodings
//   burst_beats_m1()              : HBURST -> number of beats after the first
package ahb_defs;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'd0,
        HT_BUSY   = 2'd1,
        HT_NONSEQ = 2'd2,
        HT_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        HR_OKAY  = 2'd0,
        HR_ERROR = 2'd1,
        HR_RETRY = 2'd2,
        HR_SPLIT = 2'd3
    } hresp_e;

    // Remaining beats after the NONSEQ address. Undefined-length INCR
    // counts as 0 so it never blocks arbitration through the counter.
    function automatic logic [3:0] burst_beats_m1(input logic [2:0] hburst);
        logic [3:0] n;
        case (hburst)
            HB_WRAP4,  HB_INCR4:  n = 4'd3;
            HB_WRAP8,  HB_INCR8:  n = 4'd7;
            HB_WRAP16, HB_INCR16: n = 4'd15;
            default:              n = 4'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ahb_arb_pri3.sv
// ahb_arb_pri3: combinational priority picker for three requesters.
//   req  : request vector, bit x = master x
//   last : last owner (round-robin pointer), 0..2
//   rr   : 1 = round-robin starting after last, 0 = fixed (0 highest)
//   idx  : chosen master index (valid only when vld=1)
//   vld  : at least one request is pending
module ahb_arb_pri3 (
    input  logic [2:0] req,
    input  logic [1:0] last,
    input  logic       rr,
    output logic [1:0] idx,
    output logic       vld
);

    logic [2:0] s;
    logic [1:0] c;

    always_comb begin
        idx = 2'd0;
        vld = 1'b0;
        s   = 3'd0;
        c   = 2'd0;
        if (rr) begin
            // Walk the distances from the far end so the nearest requester
            // after 'last' is the one left standing. Distance 3 is 'last'
            // itself, so a lone requester keeps the bus.
            for (int k = 3; k >= 1; k--) begin
                s = 3'({1'b0, last}) + 3'(k);
                c = (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
                if (req[c]) begin
                    idx = c;
                    vld = 1'b1;
                end
            end
        end else begin
            for (int i = 2; i >= 0; i--) begin
                if (req[i]) begin
                    idx = 2'(i);
                    vld = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter_m3.sv
// ahb_arbiter_m3: three-master AHB arbiter.
//   HCLK, HRESETn          : clock, synchronous active-low reset
//   HBUSREQ0..2, HLOCK0..2 : per-master request / lock request
//   HTRANS, HBURST, HRESP  : muxed bus control, used to track burst beats
//   HREADY                 : all state advances only when high
//   HGRANT0..2             : registered one-hot grant
//   HMASTER / HMASTERd     : address-phase / data-phase owner index
//   HMASTLOCK              : current address-phase transfer is locked
module ahb_arbiter_m3
    import ahb_defs::*;
#(
    parameter int P_NUM_MST = 3,
    parameter int P_DEFAULT = 0,
    parameter int P_RR      = 1
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       HBUSREQ0,
    input  logic       HBUSREQ1,
    input  logic       HBUSREQ2,
    input  logic       HLOCK0,
    input  logic       HLOCK1,
    input  logic       HLOCK2,
    input  logic [1:0] HTRANS,
    input  logic [2:0] HBURST,
    input  logic       HREADY,
    input  logic [1:0] HRESP,
    output logic       HGRANT0,
    output logic       HGRANT1,
    output logic       HGRANT2,
    output logic [3:0] HMASTER,
    output logic [3:0] HMASTERd,
    output logic       HMASTLOCK
);

    localparam logic [1:0] DEF_IDX = P_DEFAULT[1:0];

    logic [P_NUM_MST-1:0] req_vec;
    logic [3:0]           lock_vec;   // padded so a 2-bit index is always in range

    logic [1:0] gnt_q, mst_q, mstd_q, last_q;
    logic       lock_q, incr_q;
    logic [3:0] cnt_q, cnt_nxt;

    logic       is_nonseq, is_seq, cur_incr, permit;
    logic [1:0] pick_idx, new_idx;
    logic       pick_vld;

    assign req_vec   = {HBUSREQ2, HBUSREQ1, HBUSREQ0};
    assign lock_vec  = {1'b0, HLOCK2, HLOCK1, HLOCK0};
    assign is_nonseq = (HTRANS == HT_NONSEQ);
    assign is_seq    = (HTRANS == HT_SEQ);

    // Beats still owed after the address accepted at this edge. A non-OKAY
    // response ends the burst, even on the edge that starts a new one.
    always_comb begin
        cnt_nxt = cnt_q;
        if (is_nonseq)
            cnt_nxt = burst_beats_m1(HBURST);
        else if (is_seq && cnt_q != 4'd0)
            cnt_nxt = cnt_q - 4'd1;
        if (HRESP != HR_OKAY)
            cnt_nxt = 4'd0;
    end

    // The burst type in force at this edge: a NONSEQ brings its own.
    assign cur_incr = is_nonseq ? (HBURST == HB_INCR) : incr_q;

    assign permit = ((cnt_nxt == 4'd0) || cur_incr)
                  && !lock_vec[gnt_q]
                  && !(is_nonseq && cnt_nxt != 4'd0);

    ahb_arb_pri3 u_pri (
        .req  (req_vec),
        .last (last_q),
        .rr   (P_RR != 0),
        .idx  (pick_idx),
        .vld  (pick_vld)
    );

    assign new_idx = pick_vld ? pick_idx : DEF_IDX;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            gnt_q  <= DEF_IDX;
            mst_q  <= DEF_IDX;
            mstd_q <= DEF_IDX;
            last_q <= DEF_IDX;
            lock_q <= 1'b0;
            incr_q <= 1'b0;
            cnt_q  <= 4'd0;
        end else if (HREADY) begin
            mst_q  <= gnt_q;
            mstd_q <= mst_q;
            lock_q <= lock_vec[gnt_q];
            cnt_q  <= cnt_nxt;
            if (is_nonseq)
                incr_q <= (HBURST == HB_INCR);
            // Pointer moves only on a real handover so a re-grant to the
            // same master does not skew the rotation.
            if (permit && new_idx != gnt_q) begin
                gnt_q  <= new_idx;
                last_q <= new_idx;
            end
        end
    end

    assign HGRANT0   = (gnt_q == 2'd0);
    assign HGRANT1   = (gnt_q == 2'd1);
    assign HGRANT2   = (gnt_q == 2'd2);
    assign HMASTER   = {2'b00, mst_q};
    assign HMASTERd  = {2'b00, mstd_q};
    assign HMASTLOCK = lock_q;

endmodule

// File: tb/tb_ahb_arbiter_m3.sv
// Bench: two arbiters (round-robin and fixed priority) share one stimulus;
// a behavioural model of each is checked every cycle, plus literal checks
// on directed scenarios.
module tb_ahb_arbiter_m3;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic [2:0] breq = 3'b000;
    logic [2:0] hlock = 3'b000;
    logic [1:0] htrans = 2'd0;
    logic [2:0] hburst = 3'd0;
    logic       hready = 1'b1;
    logic [1:0] hresp = 2'd0;

    logic [2:0] gnt_rr, gnt_fx;
    logic [3:0] mst_rr, mst_fx, mstd_rr, mstd_fx;
    logic       lk_rr, lk_fx;

    int errors = 0;
    int checks = 0;

    always #5 HCLK = ~HCLK;

    ahb_arbiter_m3 #(.P_NUM_MST(3), .P_DEFAULT(0), .P_RR(1)) u_rr (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HBUSREQ0(breq[0]), .HBUSREQ1(breq[1]), .HBUSREQ2(breq[2]),
        .HLOCK0(hlock[0]), .HLOCK1(hlock[1]), .HLOCK2(hlock[2]),
        .HTRANS(htrans), .HBURST(hburst), .HREADY(hready), .HRESP(hresp),
        .HGRANT0(gnt_rr[0]), .HGRANT1(gnt_rr[1]), .HGRANT2(gnt_rr[2]),
        .HMASTER(mst_rr), .HMASTERd(mstd_rr), .HMASTLOCK(lk_rr)
    );

    ahb_arbiter_m3 #(.P_NUM_MST(3), .P_DEFAULT(0), .P_RR(0)) u_fx (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HBUSREQ0(breq[0]), .HBUSREQ1(breq[1]), .HBUSREQ2(breq[2]),
        .HLOCK0(hlock[0]), .HLOCK1(hlock[1]), .HLOCK2(hlock[2]),
        .HTRANS(htrans), .HBURST(hburst), .HREADY(hready), .HRESP(hresp),
        .HGRANT0(gnt_fx[0]), .HGRANT1(gnt_fx[1]), .HGRANT2(gnt_fx[2]),
        .HMASTER(mst_fx), .HMASTERd(mstd_fx), .HMASTLOCK(lk_fx)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model (index 0 = RR, 1 = fixed) -------
    int m_g[2], m_m[2], m_md[2], m_lk[2], m_cnt[2], m_last[2], m_incr[2];
    bit mdl_ok = 1'b0;

    function automatic int beats_after(input int b);
        // SINGLE/INCR: 0, then 4/8/16-beat families
        return (b < 2) ? 0 : (4 << ((b - 2) / 2)) - 1;
    endfunction

    always @(posedge HCLK) begin
        int  cn, pick, c;
        bit  ns, perm, ci, found;
        for (int r = 0; r < 2; r++) begin
            if (!HRESETn) begin
                m_g[r] = 0; m_m[r] = 0; m_md[r] = 0; m_lk[r] = 0;
                m_cnt[r] = 0; m_last[r] = 0; m_incr[r] = 0;
            end else if (hready) begin
                ns = (htrans == 2'd2);
                if (ns) cn = beats_after(int'(hburst));
                else if (htrans == 2'd3 && m_cnt[r] > 0) cn = m_cnt[r] - 1;
                else cn = m_cnt[r];
                if (hresp != 2'd0) cn = 0;
                ci = ns ? (hburst == 3'd1) : (m_incr[r] != 0);
                perm = (cn == 0 || ci) && !hlock[m_g[r]] && !(ns && cn > 0);
                m_md[r] = m_m[r];
                m_m[r]  = m_g[r];
                m_lk[r] = hlock[m_g[r]];
                if (perm) begin
                    pick = 0;
                    found = 0;
                    for (int k = 0; k < 3; k++) begin
                        c = (r == 0) ? (m_last[r] + 1 + k) % 3 : k;
                        if (!found && breq[c]) begin
                            pick = c;
                            found = 1;
                        end
                    end
                    if (pick != m_g[r]) begin
                        m_g[r] = pick;
                        m_last[r] = pick;
                    end
                end
                if (ns) m_incr[r] = (hburst == 3'd1);
                m_cnt[r] = cn;
            end
        end
        if (!HRESETn) mdl_ok = 1'b1;
    end

    always @(negedge HCLK) begin
        if (mdl_ok) begin
            chk("grant_rr", int'(gnt_rr), 1 << m_g[0]);
            chk("grant_fx", int'(gnt_fx), 1 << m_g[1]);
            chk("hmaster_rr", int'(mst_rr), m_m[0]);
            chk("hmaster_fx", int'(mst_fx), m_m[1]);
            chk("hmasterd_rr", int'(mstd_rr), m_md[0]);
            chk("hmasterd_fx", int'(mstd_fx), m_md[1]);
            chk("hmastlock_rr", int'(lk_rr), m_lk[0]);
            chk("hmastlock_fx", int'(lk_fx), m_lk[1]);
        end
    end

    // ---------------- stimulus ---------------------------------------------
    task automatic step();
        @(negedge HCLK);
    endtask

    task automatic idle_bus();
        breq = 3'b000; hlock = 3'b000; htrans = 2'd0; hburst = 3'd0;
        hready = 1'b1; hresp = 2'd0;
    endtask

    task automatic rst();
        idle_bus();
        HRESETn = 1'b0;
        step();
        HRESETn = 1'b1;
    endtask

    function automatic int gidx(input logic [2:0] g);
        case (g)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 9;
        endcase
    endfunction

    // INCR4 from master 1 with master 2 requesting from beat 2; optional stall
    task automatic incr4_handover(input int stall);
        rst();
        breq = 3'b010;
        step();
        chk("incr4_grant1", int'(gnt_rr), 3'b010);
        htrans = 2'd2; hburst = 3'd3;           // NONSEQ INCR4
        step();
        chk("incr4_mst1", int'(mst_rr), 1);
        htrans = 2'd3; breq = 3'b110;           // beat 2, master 2 requests
        if (stall != 0) begin
            hready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                step();
                chk("stall_grant", int'(gnt_rr), 3'b010);
                chk("stall_mst", int'(mst_rr), 1);
            end
            hready = 1'b1;
        end
        step();
        chk("incr4_b2_grant", int'(gnt_rr), 3'b010);
        step();                                 // beat 3
        chk("incr4_b3_grant", int'(gnt_rr), 3'b010);
        breq = 3'b100;
        step();                                 // beat 4
        chk("incr4_b4_grant", int'(gnt_rr), 3'b100);
        chk("incr4_b4_mst", int'(mst_rr), 1);
        htrans = 2'd0;
        step();
        chk("incr4_mst2", int'(mst_rr), 2);
        chk("incr4_mstd1", int'(mstd_rr), 1);
        step();
        chk("incr4_mstd2", int'(mstd_rr), 2);
    endtask

    initial begin
        int exp_rr[5];
        exp_rr = '{1, 2, 0, 1, 2};

        // reset, no requests, hold
        idle_bus();
        HRESETn = 1'b0;
        step(); step();
        HRESETn = 1'b1;
        chk("rst_grant", int'(gnt_rr), 3'b001);
        chk("rst_mst", int'(mst_rr), 0);
        chk("rst_mstd", int'(mstd_rr), 0);
        chk("rst_lock", int'(lk_rr), 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_hold_grant", int'(gnt_rr), 3'b001);
            chk("idle_hold_mst", int'(mst_rr), 0);
        end

        incr4_handover(0);
        incr4_handover(1);

        // rotation vs fixed priority with everyone requesting SINGLEs
        rst();
        breq = 3'b111; htrans = 2'd2; hburst = 3'd0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rr_order", gidx(gnt_rr), exp_rr[i]);
            chk("fx_order", gidx(gnt_fx), 0);
        end

        // locked INCR bursts from master 2
        rst();
        breq = 3'b100; hlock = 3'b100;
        step();
        chk("lock_grant2", int'(gnt_rr), 3'b100);
        breq = 3'b101; htrans = 2'd2; hburst = 3'd1;
        step();
        chk("lock_held", int'(gnt_rr), 3'b100);
        chk("lock_mastlock", int'(lk_rr), 1);
        htrans = 2'd3;
        step(); step();
        chk("lock_held2", int'(gnt_rr), 3'b100);
        chk("lock_held2_fx", int'(gnt_fx), 3'b100);
        hlock = 3'b000;
        step();
        chk("unlock_grant0", int'(gnt_rr), 3'b001);
        chk("unlock_grant0_fx", int'(gnt_fx), 3'b001);

        // INCR8 terminated by ERROR on beat 3
        rst();
        breq = 3'b010; htrans = 2'd2; hburst = 3'd5;
        step();
        chk("err_b1_grant", int'(gnt_rr), 3'b001);
        htrans = 2'd3;
        step();
        chk("err_b2_grant", int'(gnt_rr), 3'b001);
        hresp = 2'd1;
        step();
        chk("err_grant1", int'(gnt_rr), 3'b010);
        chk("err_grant1_fx", int'(gnt_fx), 3'b010);
        hresp = 2'd0;

        // randomized traffic, checked against the model every cycle
        rst();
        for (int i = 0; i < 3000; i++) begin
            breq   = 3'($urandom_range(0, 7));
            hlock  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            htrans = 2'($urandom_range(0, 3));
            hburst = 3'($urandom_range(0, 7));
            hready = ($urandom_range(0, 3) != 0);
            hresp  = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            HRESETn = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
